// File: rtl/reram_seq_pkg.sv
// Shared types and constants for the ReRAM Wishbone burst sequencer.
package reram_seq_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned TMO_W  = 16;

  typedef enum logic [2:0] {IDLE, FETCH, REQ, RESP, DONE, ERR} state_t;

  localparam logic OP_WRITE    = 1'b0;
  localparam logic OP_READ     = 1'b1;
  localparam logic WB_WE_WRITE = 1'b0;
  localparam logic WB_WE_READ  = 1'b1;

  localparam logic [SEL_W-1:0] SEL_ALL_DFLT = 4'hF;

endpackage

// File: rtl/reram_wb_sequencer_if.sv
// Wishbone classic bus between the sequencer (master) and the ReRAM wrapper (slave).
interface reram_wb_sequencer_if;
  import reram_seq_pkg::*;

  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [SEL_W-1:0]  wbm_sel_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [DATA_W-1:0] wbm_dat_o;
  logic [DATA_W-1:0] wbm_dat_i;
  logic              wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface

// File: rtl/reram_seq_timeout.sv
// Per-request ack watchdog: counts unacknowledged REQ cycles, flags the TIMEOUT-th one.
module reram_seq_timeout
  import reram_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  logic [TMO_W-1:0] count;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TMO_W'(1);
    end
  end

  // count holds the number of earlier unacked cycles, so this is the TIMEOUT-th one
  assign expired_c = enable && (count == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/reram_wb_sequencer.sv
// Burst-to-single-cycle Wishbone master feeding the ReRAM slave wrapper.
module reram_wb_sequencer
  import reram_seq_pkg::*;
#(
  parameter int unsigned      ADDR_STRIDE = 4,
  parameter int unsigned      TIMEOUT     = 255,
  parameter logic [SEL_W-1:0] SEL_ALL     = reram_seq_pkg::SEL_ALL_DFLT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic              err,
  reram_wb_sequencer_if.master bus
);

  state_t            state;
  logic              op;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic              expired_c;

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == FETCH);

  // Ack suppresses the watchdog, so an ack on the last allowed cycle still succeeds
  reram_seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .clear     (state != REQ),
    .enable    ((state == REQ) && !bus.wbm_ack_i),
    .expired_c (expired_c)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      op            <= OP_WRITE;
      cur_addr      <= '0;
      remaining     <= '0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      bus.wbm_cyc_o <= 1'b0;
      bus.wbm_stb_o <= 1'b0;
      bus.wbm_we_o  <= 1'b0;
      bus.wbm_sel_o <= '0;
      bus.wbm_adr_o <= '0;
      bus.wbm_dat_o <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op        <= cmd_op;
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            if (cmd_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (cmd_op == OP_WRITE) begin
              state <= FETCH;
            end else begin
              state         <= REQ;
              bus.wbm_cyc_o <= 1'b1;
              bus.wbm_stb_o <= 1'b1;
              bus.wbm_we_o  <= WB_WE_READ;
              bus.wbm_sel_o <= SEL_ALL;
              bus.wbm_adr_o <= cmd_addr;
            end
          end
        end
        FETCH: begin
          if (wr_valid) begin
            state         <= REQ;
            bus.wbm_dat_o <= wr_data;
            bus.wbm_cyc_o <= 1'b1;
            bus.wbm_stb_o <= 1'b1;
            bus.wbm_we_o  <= WB_WE_WRITE;
            bus.wbm_sel_o <= SEL_ALL;
            bus.wbm_adr_o <= cur_addr;
          end
        end
        REQ: begin
          if (bus.wbm_ack_i) begin
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            cur_addr      <= cur_addr + ADDR_W'(ADDR_STRIDE);
            remaining     <= remaining - LEN_W'(1);
            if (op == OP_READ) begin
              rd_data  <= bus.wbm_dat_i;
              rd_valid <= 1'b1;
              state    <= RESP;
            end else if (remaining > LEN_W'(1)) begin
              state <= FETCH;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (expired_c) begin
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            state         <= ERR;
            err           <= 1'b1;
          end
        end
        RESP: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            if (remaining != '0) begin
              state         <= REQ;
              bus.wbm_cyc_o <= 1'b1;
              bus.wbm_stb_o <= 1'b1;
              bus.wbm_we_o  <= WB_WE_READ;
              bus.wbm_sel_o <= SEL_ALL;
              bus.wbm_adr_o <= cur_addr;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reram_wb_sequencer.sv
// Directed bench for reram_wb_sequencer with a latency-programmable Wishbone slave model.
module tb_reram_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [31:0] wr_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        done;
  logic        err;

  reram_wb_sequencer_if wb ();

  reram_wb_sequencer #(.ADDR_STRIDE(4), .TIMEOUT(8), .SEL_ALL(4'hF)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .done      (done),
    .err       (err),
    .bus       (wb)
  );

  always #5 clk = ~clk;

  // Slave model: ack lands in stb-cycle slv_lat+2; never acks when slv_en is 0
  logic        slv_en = 1'b1;
  int          slv_lat = 0;
  int          slv_cnt = 0;
  logic [31:0] rq [8];
  logic [2:0]  rd_idx;

  // Monitor counters and per-access log, cleared by clr_mon
  logic        clr_mon = 1'b0;
  logic [31:0] wq [8];
  logic [2:0]  wr_taken;
  logic        cyc_q;
  int          cyc_rises, stb_cycles, done_cnt, err_cnt, both_cnt;
  logic [3:0]  log_n;
  logic [31:0] log_adr [8];
  logic [31:0] log_dat [8];
  logic        log_we  [8];
  logic [3:0]  log_sel [8];

  int n_pass  = 0;
  int n_total = 0;

  always_comb wr_data = wq[wr_taken];

  always @(posedge clk) begin
    if (wb.wbm_cyc_o && wb.wbm_stb_o && !wb.wbm_ack_i && slv_en) begin
      if (slv_cnt == slv_lat) begin
        wb.wbm_ack_i <= 1'b1;
        wb.wbm_dat_i <= rq[rd_idx];
        rd_idx       <= rd_idx + 3'd1;
      end else begin
        slv_cnt <= slv_cnt + 1;
      end
    end else begin
      wb.wbm_ack_i <= 1'b0;
      slv_cnt      <= 0;
    end
    if (clr_mon) rd_idx <= '0;
  end

  always @(posedge clk) begin
    if (clr_mon) begin
      wr_taken <= '0; cyc_q <= 1'b0; cyc_rises <= 0; stb_cycles <= 0;
      done_cnt <= 0; err_cnt <= 0; both_cnt <= 0; log_n <= '0;
    end else begin
      cyc_q <= wb.wbm_cyc_o;
      if (wb.wbm_cyc_o && !cyc_q) cyc_rises <= cyc_rises + 1;
      if (wb.wbm_stb_o) stb_cycles <= stb_cycles + 1;
      if (wr_valid && wr_ready) wr_taken <= wr_taken + 3'd1;
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (done && err) both_cnt <= both_cnt + 1;
      if (wb.wbm_stb_o && wb.wbm_ack_i) begin
        log_adr[log_n[2:0]] <= wb.wbm_adr_o;
        log_dat[log_n[2:0]] <= wb.wbm_dat_o;
        log_we[log_n[2:0]]  <= wb.wbm_we_o;
        log_sel[log_n[2:0]] <= wb.wbm_sel_o;
        log_n <= log_n + 4'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    tick();
    clr_mon = 1'b0;
  endtask

  task automatic send_cmd(input logic op, input logic [31:0] addr, input logic [7:0] len);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int max);
    int n = 0;
    while (!(done || err) && n < max) begin
      tick();
      n++;
    end
    n_total++;
    assert (n < max) n_pass++;
    else $error("FAIL %s: observed no done/err within %0d cycles, expected a pulse", tag, max);
  endtask

  task automatic wait_rd(input string tag, input int max);
    int n = 0;
    while (!rd_valid && n < max) begin
      tick();
      n++;
    end
    n_total++;
    assert (n < max) n_pass++;
    else $error("FAIL %s: observed no rd_valid within %0d cycles, expected one", tag, max);
  endtask

  initial begin
    wb.wbm_ack_i = 1'b0;
    wb.wbm_dat_i = '0;
    for (int i = 0; i < 8; i++) begin
      wq[i] = '0;
      rq[i] = '0;
    end
    clr_mon = 1'b1;
    tick(); tick();
    rst = 1'b0;
    clr_mon = 1'b0;

    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cyc", 32'(wb.wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb.wbm_stb_o), 32'd0);
    chk("rst_sel", 32'(wb.wbm_sel_o), 32'd0);
    chk("rst_adr", wb.wbm_adr_o, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);

    // Write burst of three words
    wq[0] = 32'hA1; wq[1] = 32'hB2; wq[2] = 32'hC3;
    slv_en = 1'b1; slv_lat = 0; wr_valid = 1'b1;
    clear_mon();
    send_cmd(1'b0, 32'h3000_0000, 8'd3);
    wait_end("wr_end", 60);
    chk("wr_done", 32'(done), 32'd1);
    tick();
    chk("wr_done_once", 32'(done), 32'd0);
    chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("wr_cyc_rises", 32'(cyc_rises), 32'd3);
    chk("wr_accesses", 32'(log_n), 32'd3);
    chk("wr_adr0", log_adr[0], 32'h3000_0000);
    chk("wr_adr1", log_adr[1], 32'h3000_0004);
    chk("wr_adr2", log_adr[2], 32'h3000_0008);
    chk("wr_dat0", log_dat[0], 32'hA1);
    chk("wr_dat1", log_dat[1], 32'hB2);
    chk("wr_dat2", log_dat[2], 32'hC3);
    chk("wr_we", 32'({log_we[0], log_we[1], log_we[2]}), 32'd0);
    chk("wr_sel", 32'(log_sel[0]), 32'hF);
    chk("wr_taken", 32'(wr_taken), 32'd3);
    chk("wr_done_cnt", 32'(done_cnt), 32'd1);

    // Read burst with five cycles of backpressure on word 1
    rq[0] = 32'hDEAD_BEEF; rq[1] = 32'h1234_5678;
    wr_valid = 1'b0; rd_ready = 1'b0;
    clear_mon();
    send_cmd(1'b1, 32'h10, 8'd2);
    wait_rd("rd_w1", 30);
    chk("rd_w1_data", rd_data, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) tick();
    chk("rd_hold_data", rd_data, 32'hDEAD_BEEF);
    chk("rd_hold_valid", 32'(rd_valid), 32'd1);
    chk("rd_hold_no_stb", 32'(cyc_rises), 32'd1);
    chk("rd_hold_stb", 32'(wb.wbm_stb_o), 32'd0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("rd_valid_drop", 32'(rd_valid), 32'd0);
    wait_rd("rd_w2", 30);
    chk("rd_w2_data", rd_data, 32'h1234_5678);
    chk("rd_no_done_yet", 32'(done_cnt), 32'd0);
    rd_ready = 1'b1;
    wait_end("rd_end", 10);
    rd_ready = 1'b0;
    tick();
    chk("rd_done_cnt", 32'(done_cnt), 32'd1);
    chk("rd_adr0", log_adr[0], 32'h10);
    chk("rd_adr1", log_adr[1], 32'h14);
    chk("rd_we", 32'({log_we[0], log_we[1]}), 32'd3);

    // Zero-length command
    wr_valid = 1'b1; wq[0] = 32'h5555;
    clear_mon();
    send_cmd(1'b0, 32'h100, 8'd0);
    chk("len0_done", 32'(done), 32'd1);
    tick();
    chk("len0_done_drop", 32'(done), 32'd0);
    chk("len0_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("len0_no_cyc", 32'(cyc_rises), 32'd0);
    chk("len0_no_wr", 32'(wr_taken), 32'd0);

    // Timeout: slave never acks the first write word
    slv_en = 1'b0;
    clear_mon();
    send_cmd(1'b0, 32'h200, 8'd3);
    wait_end("tmo_end", 40);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_no_done", 32'(done), 32'd0);
    chk("tmo_cyc", 32'(wb.wbm_cyc_o), 32'd0);
    chk("tmo_stb", 32'(wb.wbm_stb_o), 32'd0);
    tick();
    chk("tmo_err_drop", 32'(err), 32'd0);
    chk("tmo_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("tmo_stb_cycles", 32'(stb_cycles), 32'd8);
    chk("tmo_wr_taken", 32'(wr_taken), 32'd1);
    chk("tmo_err_cnt", 32'(err_cnt), 32'd1);
    chk("tmo_done_cnt", 32'(done_cnt), 32'd0);

    // Ack on the last allowed cycle wins over the timeout
    slv_en = 1'b1; slv_lat = 6; rq[0] = 32'hCAFE_F00D; rd_ready = 1'b1;
    clear_mon();
    send_cmd(1'b1, 32'h400, 8'd1);
    wait_end("ack8_end", 40);
    chk("ack8_done", 32'(done), 32'd1);
    chk("ack8_no_err", 32'(err), 32'd0);
    tick();
    rd_ready = 1'b0;
    chk("ack8_stb_cycles", 32'(stb_cycles), 32'd8);
    chk("ack8_rd_data", rd_data, 32'hCAFE_F00D);
    chk("ack8_err_cnt", 32'(err_cnt), 32'd0);

    // Address wraps past 2^32
    slv_lat = 0; wq[0] = 32'h11; wq[1] = 32'h22;
    clear_mon();
    send_cmd(1'b0, 32'hFFFF_FFFC, 8'd2);
    wait_end("wrap_end", 40);
    tick();
    chk("wrap_adr0", log_adr[0], 32'hFFFF_FFFC);
    chk("wrap_adr1", log_adr[1], 32'h0000_0000);
    chk("wrap_dat1", log_dat[1], 32'h22);
    chk("wrap_done_cnt", 32'(done_cnt), 32'd1);

    // Reset during REQ of word 2 of 4
    slv_lat = 3;
    for (int i = 0; i < 4; i++) wq[i] = 32'h700 + 32'(i);
    clear_mon();
    send_cmd(1'b0, 32'h500, 8'd4);
    begin
      int k = 0;
      while (!(log_n == 4'd1 && wb.wbm_stb_o) && k < 40) begin
        tick();
        k++;
      end
      chk("mid_reached_w2", 32'(k < 40), 32'd1);
    end
    chk("mid_w2_adr", wb.wbm_adr_o, 32'h504);
    rst = 1'b1;
    tick();
    chk("mid_cyc", 32'(wb.wbm_cyc_o), 32'd0);
    chk("mid_stb", 32'(wb.wbm_stb_o), 32'd0);
    chk("mid_done_err", 32'({done, err}), 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    tick(); tick();
    chk("mid_no_done", 32'(done_cnt), 32'd0);
    chk("mid_no_err", 32'(err_cnt), 32'd0);

    // A fresh burst after the mid-burst reset
    slv_lat = 0; wq[0] = 32'h600D_0001;
    clear_mon();
    send_cmd(1'b0, 32'h600, 8'd1);
    wait_end("post_end", 30);
    chk("post_done", 32'(done), 32'd1);
    tick();
    chk("post_adr", log_adr[0], 32'h600);
    chk("post_dat", log_dat[0], 32'h600D_0001);
    chk("post_both", 32'(both_cnt), 32'd0);
    wr_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reram_wb_sequencer.md
Name: reram_wb_sequencer

Overview:
- Wishbone master that sits directly upstream of the ReRAM Wishbone slave wrapper.
- Turns single burst commands (op, base address, word count) into a series of single-word Wishbone classic cycles.
- Streams write data in and read data out, with backpressure on both streams.
- Used by the weight-load and readback engines so they never drive the bus protocol directly.

Parameters:
- ADDR_STRIDE, 4: byte increment of the address after each word.
- TIMEOUT, 255: cycles allowed in REQ without ack before abort; legal range 1..65535.
- SEL_ALL, 4'hF: value driven on wbm_sel_o for every access.

Ports:
- wb_clk_i  in  1  clock; the only clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer idle, accepts command.
- cmd_op  in  1  0 = write burst, 1 = read burst.
- cmd_addr  in  32  base byte address.
- cmd_len  in  8  word count; 0 = no-op.
- wr_data  in  32  write word.
- wr_valid  in  1  write word present.
- wr_ready  out  1  write word consumed.
- rd_data  out  32  read word.
- rd_valid  out  1  read word present.
- rd_ready  in  1  consumer takes read word.
- done  out  1  one-cycle pulse: burst completed.
- err  out  1  one-cycle pulse: burst aborted on timeout.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  bus direction: 0 = write, 1 = read (slave convention).
- wbm_sel_o  out  4  byte select.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data from slave.
- wbm_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset (sync, active-high) values: state IDLE; cyc, stb, we, adr, dat_o, rd_data, rd_valid, done, err all 0; sel 0.
- Reset applies at the next edge even mid-burst. No done or err is pulsed, and the remaining words are discarded.
- cmd_ready is 1 exactly when state = IDLE, so it is high the first cycle after reset deasserts.
- IDLE: on cmd_valid & cmd_ready, latch op, addr into cur_addr, and len into remaining.
  - len = 0: go to DONE. No bus activity, no stream handshake.
  - op = 0: go to FETCH.
  - op = 1: go to REQ.
- FETCH (write only): wr_ready = 1 combinationally in this state.
  - On wr_valid, register wr_data into wbm_dat_o and go to REQ.
- REQ: cyc = stb = 1; we = op; adr = cur_addr; sel = SEL_ALL. All are registered, valid from the first REQ cycle.
  - A timeout counter clears on REQ entry and increments each REQ cycle without ack.
- ack_i seen in REQ:
  - cyc and stb are 0 the next cycle; every word is its own Wishbone cycle.
  - cur_addr += ADDR_STRIDE, wrapping mod 2^32; remaining -= 1.
  - Write: go to FETCH if remaining > 0 after the decrement, else DONE.
  - Read: capture wbm_dat_i into rd_data, set rd_valid = 1, go to RESP.
- RESP: hold rd_data and rd_valid until rd_ready.
  - On rd_valid & rd_ready: rd_valid = 0 next cycle; go to REQ if remaining > 0, else DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Timeout: counter reaches TIMEOUT in REQ with no ack.
  - cyc and stb drop next cycle; state goes to ERR.
  - ERR: err = 1 for one cycle, then IDLE.
  - Unsent write words are not consumed (wr_ready stays 0).
- Ignored/ordered events:
  - ack_i outside REQ is ignored.
  - An ack arriving in the same cycle the counter reaches TIMEOUT counts as success; ack wins.
- Minimum latency per word:
  - Write: wr handshake, then REQ next cycle; ack k cycles later; next FETCH one cycle after ack.
  - Read: ack, then rd_valid next cycle.
- Invariants:
  - done and err are never high together.
  - At most one burst is outstanding.

Decomposition:
- Package reram_seq_pkg holds:
  - state enum {IDLE, FETCH, REQ, RESP, DONE, ERR};
  - constants OP_WRITE = 0 and OP_READ = 1;
  - constants WB_WE_WRITE = 0 and WB_WE_READ = 1;
  - default SEL_ALL.
- One sub-module, reram_seq_timeout: a clear/enable counter with an expired flag, parameterised by TIMEOUT.
- The FSM and datapath stay in reram_wb_sequencer.

Test Plan:
- Write burst: op = 0, addr = 0x3000_0000, len = 3, wr words 0xA1, 0xB2, 0xC3; slave acks 2 cycles after stb.
  - Expect three separate cyc pulses with we = 0, adr 0x3000_0000, 0x3000_0004, 0x3000_0008, dat_o matching in order.
  - done pulses once after the third ack; cmd_ready returns to 1.
- Read burst with backpressure: op = 1, addr = 0x10, len = 2, slave returns 0xDEAD_BEEF then 0x1234_5678, rd_ready held low 5 cycles on word 1.
  - Expect rd_data held stable, no second stb until the rd handshake, we = 1, done after the second rd handshake.
- len = 0: no cyc, no wr_ready, done one cycle after command accept.
- Timeout with TIMEOUT = 8: slave never acks.
  - Expect stb high exactly 8 cycles, then cyc = stb = 0 and err pulse.
  - Remaining write words are not consumed.
  - Repeat with ack on cycle 8: success, no err.
- Address wrap: addr = 0xFFFF_FFFC, len = 2, write.
  - Expect adr 0xFFFF_FFFC then 0x0000_0000.
- Mid-burst reset asserted during REQ of word 2 of 4.
  - Expect cyc = stb = 0 next edge, no done/err, cmd_ready = 1 after release.
  - A new burst then runs normally.
